hazard_ctrl_unit: RTL and testbench

Parametrised successor to the single-signal branch stall block. Central pipeline hazard controller for the 5-stage RV32I core. Produces PC/IF-ID/ID-EX stall and flush controls for four cases:
- control transfers, with a configurable bubble count and prediction mode;
- load-use data hazards;
- external memory wait;
- a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_unit_if.sv | 39 +++
 rtl/hazard_ctrl_unit.sv | 115 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bus: pipeline hazard inputs and the stall/flush controls it returns.
// The master drives the pipeline-side inputs; the slave is the hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic [1:0]            branch;
    logic                  branch_taken;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  mem_busy;
    logic                  cnt_clr;

    logic                  pc_stall;
    logic                  IF_ID_stall;
    logic                  IF_ID_flush;
    logic                  ID_EX_stall;
    logic                  ID_EX_flush;
    logic                  flush_busy;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output branch, branch_taken, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_mem_read, mem_busy, cnt_clr,
        input  pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               flush_busy, stall_cycles
    );

    modport slave (
        input  branch, branch_taken, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_mem_read, mem_busy, cnt_clr,
        output pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               flush_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Central pipeline hazard controller: control-transfer flushes, load-use stalls,
// memory-wait freeze and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PREDICT_NT   = 0,
    parameter int unsigned CNT_W        = 32
) (
    input logic              clk,
    input logic              rst,
    hazard_ctrl_unit_if.slave hz
);
    localparam int unsigned        FCNT_W = 3;
    localparam logic [FCNT_W-1:0]  RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam bit                 MULTI  = (FLUSH_CYCLES > 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("hazard_ctrl_unit: FLUSH_CYCLES=%0d outside 1..7", FLUSH_CYCLES);
    end

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state;
    logic [FCNT_W-1:0]     fcnt;
    logic [CNT_W-1:0]      cnt;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  xfer_c, lu_hazard_c;
    logic                  pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c;

    assign rs1 = hz.id_rs1;
    assign rs2 = hz.id_rs2;
    assign rd  = hz.ex_rd;

    // Hazard detection from current EX/ID contents
    always_comb begin
        xfer_c = (hz.branch != 2'b00);
        if (PREDICT_NT != 0) begin
            xfer_c = xfer_c && hz.branch_taken;
        end
        lu_hazard_c = hz.ex_mem_read && (rd != '0) &&
                      ((hz.id_rs1_used && (rs1 == rd)) || (hz.id_rs2_used && (rs2 == rd)));
    end

    // Zero-latency controls; priority mem_busy > xfer > load-use, load-use masked in FLUSH
    always_comb begin
        pc_stall_c    = 1'b0;
        if_id_stall_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_stall_c = 1'b0;
        id_ex_flush_c = 1'b0;
        if (hz.mem_busy) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_stall_c = 1'b1;
        end else if (state == FLUSH) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = xfer_c;
        end else if (xfer_c) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (lu_hazard_c) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.IF_ID_stall  = if_id_stall_c;
    assign hz.IF_ID_flush  = if_id_flush_c;
    assign hz.ID_EX_stall  = id_ex_stall_c;
    assign hz.ID_EX_flush  = id_ex_flush_c;
    assign hz.flush_busy   = (state == FLUSH);
    assign hz.stall_cycles = cnt;

    // Bubble sequencer; frozen entirely while memory is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else if (!hz.mem_busy) begin
            case (state)
                RUN: begin
                    if (xfer_c && MULTI) begin
                        state <= FLUSH;
                        fcnt  <= RELOAD;
                    end
                end
                FLUSH: begin
                    if (xfer_c) begin
                        fcnt <= RELOAD;
                    end else if (fcnt == FCNT_W'(1)) begin
                        state <= RUN;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    fcnt  <= '0;
                end
            endcase
        end
    end

    // Saturating stall counter; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || hz.cnt_clr) begin
            cnt <= '0;
        end else if (pc_stall_c && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit across three parameter sets.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // a: PREDICT_NT=0, FLUSH_CYCLES=1; b: PREDICT_NT=1, FLUSH_CYCLES=3; c: PREDICT_NT=0, FLUSH_CYCLES=3, CNT_W=4
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) ia ();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) ib ();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(4))  ic ();

    hazard_ctrl_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .PREDICT_NT(0), .CNT_W(32))
        dut_a (.clk(clk), .rst(rst), .hz(ia.slave));
    hazard_ctrl_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .PREDICT_NT(1), .CNT_W(32))
        dut_b (.clk(clk), .rst(rst), .hz(ib.slave));
    hazard_ctrl_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .PREDICT_NT(0), .CNT_W(4))
        dut_c (.clk(clk), .rst(rst), .hz(ic.slave));

    // {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, flush_busy}
    logic [5:0] ctl_a, ctl_b, ctl_c;
    assign ctl_a = {ia.pc_stall, ia.IF_ID_stall, ia.IF_ID_flush, ia.ID_EX_stall, ia.ID_EX_flush, ia.flush_busy};
    assign ctl_b = {ib.pc_stall, ib.IF_ID_stall, ib.IF_ID_flush, ib.ID_EX_stall, ib.ID_EX_flush, ib.flush_busy};
    assign ctl_c = {ic.pc_stall, ic.IF_ID_stall, ic.IF_ID_flush, ic.ID_EX_stall, ic.ID_EX_flush, ic.flush_busy};

    localparam logic [5:0] IDLE   = 6'b000000;
    localparam logic [5:0] XFER   = 6'b001010;
    localparam logic [5:0] FLSH   = 6'b001001;
    localparam logic [5:0] FLSHX  = 6'b001011;
    localparam logic [5:0] LU     = 6'b110010;
    localparam logic [5:0] BUSYF  = 6'b110101;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        ia.branch = 2'b00; ia.branch_taken = 1'b0; ia.id_rs1 = '0; ia.id_rs2 = '0;
        ia.id_rs1_used = 1'b0; ia.id_rs2_used = 1'b0; ia.ex_rd = '0; ia.ex_mem_read = 1'b0;
        ia.mem_busy = 1'b0; ia.cnt_clr = 1'b0;
        ib.branch = 2'b00; ib.branch_taken = 1'b0; ib.id_rs1 = '0; ib.id_rs2 = '0;
        ib.id_rs1_used = 1'b0; ib.id_rs2_used = 1'b0; ib.ex_rd = '0; ib.ex_mem_read = 1'b0;
        ib.mem_busy = 1'b0; ib.cnt_clr = 1'b0;
        ic.branch = 2'b00; ic.branch_taken = 1'b0; ic.id_rs1 = '0; ic.id_rs2 = '0;
        ic.id_rs1_used = 1'b0; ic.id_rs2_used = 1'b0; ic.ex_rd = '0; ic.ex_mem_read = 1'b0;
        ic.mem_busy = 1'b0; ic.cnt_clr = 1'b0;
    endtask

    // Each step: drive at negedge, check combinational outputs 1 time unit later
    initial begin
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk); idle_all(); #1;
            chk("idle_ctl_a", 32'(ctl_a), 32'(IDLE));
        end
        chk("idle_ctl_b", 32'(ctl_b), 32'(IDLE));
        chk("idle_ctl_c", 32'(ctl_c), 32'(IDLE));
        chk("idle_cnt_a", ia.stall_cycles, 32'd0);
        chk("idle_cnt_c", 32'(ic.stall_cycles), 32'd0);

        // Single-cycle legacy flush
        @(negedge clk); idle_all(); ia.branch = 2'b01; #1;
        chk("a_xfer", 32'(ctl_a), 32'(XFER));
        @(negedge clk); idle_all(); #1;
        chk("a_xfer_after", 32'(ctl_a), 32'(IDLE));

        // Predict-not-taken: not-taken, then taken with 3 bubbles
        @(negedge clk); idle_all(); ib.branch = 2'b10; ib.branch_taken = 1'b0; #1;
        chk("b_nt", 32'(ctl_b), 32'(IDLE));
        @(negedge clk); idle_all(); ib.branch = 2'b10; ib.branch_taken = 1'b1; #1;
        chk("b_taken_c1", 32'(ctl_b), 32'(XFER));
        @(negedge clk); idle_all(); #1;
        chk("b_taken_c2", 32'(ctl_b), 32'(FLSH));
        @(negedge clk); idle_all(); #1;
        chk("b_taken_c3", 32'(ctl_b), 32'(FLSH));
        @(negedge clk); idle_all(); #1;
        chk("b_taken_c4", 32'(ctl_b), 32'(IDLE));

        // Load-use on rs2, then same with ex_rd=0
        @(negedge clk); idle_all();
        ia.ex_mem_read = 1'b1; ia.ex_rd = 5'd5; ia.id_rs2 = 5'd5; ia.id_rs2_used = 1'b1; #1;
        chk("a_lu", 32'(ctl_a), 32'(LU));
        @(negedge clk); idle_all(); #1;
        chk("a_lu_clear", 32'(ctl_a), 32'(IDLE));
        chk("a_lu_cnt", ia.stall_cycles, 32'd1);
        @(negedge clk); idle_all();
        ia.ex_mem_read = 1'b1; ia.ex_rd = 5'd0; ia.id_rs2 = 5'd0; ia.id_rs2_used = 1'b1; #1;
        chk("a_lu_x0", 32'(ctl_a), 32'(IDLE));
        @(negedge clk); idle_all(); #1;
        chk("a_lu_x0_cnt", ia.stall_cycles, 32'd1);

        // Memory wait freezing a 3-cycle flush
        @(negedge clk); idle_all(); ic.branch = 2'b01; #1;
        chk("c_xfer", 32'(ctl_c), 32'(XFER));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle_all(); ic.mem_busy = 1'b1; #1;
            chk("c_busy_in_flush", 32'(ctl_c), 32'(BUSYF));
        end
        @(negedge clk); idle_all(); #1;
        chk("c_resume_f2", 32'(ctl_c), 32'(FLSH));
        @(negedge clk); idle_all(); #1;
        chk("c_resume_f3", 32'(ctl_c), 32'(FLSH));
        @(negedge clk); idle_all(); #1;
        chk("c_resume_run", 32'(ctl_c), 32'(IDLE));
        chk("c_busy_cnt", 32'(ic.stall_cycles), 32'd4);

        // Simultaneous xfer and load-use: flush wins
        @(negedge clk); idle_all();
        ia.branch = 2'b01; ia.ex_mem_read = 1'b1; ia.ex_rd = 5'd7; ia.id_rs1 = 5'd7; ia.id_rs1_used = 1'b1; #1;
        chk("a_xfer_lu", 32'(ctl_a), 32'(XFER));
        @(negedge clk); idle_all(); #1;
        chk("a_xfer_lu_cnt", ia.stall_cycles, 32'd1);

        // New xfer in FLUSH reloads, load-use masked
        @(negedge clk); idle_all(); ib.branch = 2'b11; ib.branch_taken = 1'b1; #1;
        chk("b_xfer1", 32'(ctl_b), 32'(XFER));
        @(negedge clk); idle_all(); ib.branch = 2'b01; ib.branch_taken = 1'b1;
        ib.ex_mem_read = 1'b1; ib.ex_rd = 5'd3; ib.id_rs1 = 5'd3; ib.id_rs1_used = 1'b1; #1;
        chk("b_xfer_in_flush", 32'(ctl_b), 32'(FLSHX));
        @(negedge clk); idle_all(); #1;
        chk("b_reload_f2", 32'(ctl_b), 32'(FLSH));
        @(negedge clk); idle_all(); #1;
        chk("b_reload_f3", 32'(ctl_b), 32'(FLSH));
        @(negedge clk); idle_all(); #1;
        chk("b_reload_run", 32'(ctl_b), 32'(IDLE));
        chk("b_cnt", ib.stall_cycles, 32'd0);

        // Saturation of the 4-bit counter starting from 4
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); idle_all(); ic.mem_busy = 1'b1; #1;
            chk("c_sat_ramp", 32'(ic.stall_cycles), (4 + i > 15) ? 32'd15 : 32'(4 + i));
        end
        @(negedge clk); idle_all(); #1;
        chk("c_sat_final", 32'(ic.stall_cycles), 32'd15);

        // Clear overrides a concurrent stall
        @(negedge clk); idle_all(); ic.mem_busy = 1'b1; ic.cnt_clr = 1'b1; #1;
        @(negedge clk); idle_all(); #1;
        chk("c_clr", 32'(ic.stall_cycles), 32'd0);

        // Reset mid-FLUSH discards remaining bubbles
        @(negedge clk); idle_all(); ib.branch = 2'b10; ib.branch_taken = 1'b1; #1;
        chk("b_pre_rst", 32'(ctl_b), 32'(XFER));
        @(negedge clk); idle_all(); rst = 1'b1;
        @(negedge clk); idle_all(); rst = 1'b0; #1;
        chk("b_post_rst", 32'(ctl_b), 32'(IDLE));
        chk("a_post_rst_cnt", ia.stall_cycles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
